// File: rtl/top_k_select_scan.sv
// top_k_select_scan
//
// Scans one processor's key range in DDR after the top-K threshold stage has
// sampled its threshold. The range is read in bursts of up to BURST_KEYS
// 32-byte records. Every record whose delta field is at or above the latched
// threshold is written to the work FIFO, up to an optional cap. A one-cycle
// key_selection_done pulse marks the end of each accepted scan.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start_key_process           one-cycle start pulse (ignored while busy)
//   threshold                   priority threshold, latched at start
//   key_start, key_end          key range [key_start, key_end), latched at start
//   max_select                  cap on emitted keys per scan (0 = no cap)
//   control_*                   burst read-master command/handshake
//   user_read_buffer            pop one record from the read master
//   user_data_available         a record is present on user_buffer_data
//   user_buffer_data            record: [31:0] key, [95:64] delta
//   fifo_wrreq, fifo_data       work FIFO write port, data = {delta, key}
//   fifo_almost_full            stall request from the work FIFO
//   selected_count              keys emitted in the current/last scan
//   key_selection_done          one-cycle completion pulse
//   busy                        high from the start pulse until the done pulse
module top_k_select_scan #(
  parameter int                       ADDRESS_WIDTH   = 31,
  parameter logic [ADDRESS_WIDTH-1:0] DDR_BASE        = '0,
  parameter int                       BURST_KEYS      = 8,
  parameter int                       FIFO_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_key_process,
  input  logic [31:0]                threshold,
  input  logic [31:0]                key_start,
  input  logic [31:0]                key_end,
  input  logic [31:0]                max_select,
  output logic                       control_fixed_location,
  output logic [ADDRESS_WIDTH-1:0]   control_read_base,
  output logic [ADDRESS_WIDTH-1:0]   control_read_length,
  output logic                       control_go,
  input  logic                       control_done,
  output logic                       user_read_buffer,
  input  logic                       user_data_available,
  input  logic [255:0]               user_buffer_data,
  output logic                       fifo_wrreq,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       fifo_almost_full,
  output logic [31:0]                selected_count,
  output logic                       key_selection_done,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_POP, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] thr_q, end_q, max_q, cur_key_q, left_q;
  logic        done_seen_q;

  logic [31:0] thr_d, end_d, max_d, cur_d, left_d, count_d;
  logic        done_seen_d, go_d, rd_d, wr_d, done_d, busy_d;
  logic [ADDRESS_WIDTH-1:0]   base_d, len_d;
  logic [FIFO_DATA_WIDTH-1:0] data_d;

  logic [31:0] rec_key, rec_delta, remaining, chunk;
  logic        qualifies, cap_reached, range_left, rec_ready, burst_done;
  logic        unused_rec_bits;

  assign control_fixed_location = 1'b0;

  assign rec_key         = user_buffer_data[31:0];
  assign rec_delta       = user_buffer_data[95:64];
  assign unused_rec_bits = ^{user_buffer_data[255:96], user_buffer_data[63:32]};

  // Deltas are non-negative IEEE-754 singles, so unsigned integer order is
  // the same as float order.
  assign qualifies   = rec_delta >= thr_q;
  assign cap_reached = (max_q != 32'd0) && (selected_count == max_q);
  assign range_left  = cur_key_q < end_q;
  assign rec_ready   = user_data_available && !fifo_almost_full;
  // control_done may arrive while records are still being consumed; the
  // sticky copy keeps it for DRAIN.
  assign burst_done  = done_seen_q || control_done;
  assign remaining   = end_q - cur_key_q;
  assign chunk       = (remaining < 32'(BURST_KEYS)) ? remaining : 32'(BURST_KEYS);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // loads from values that were stable before the edge.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. An empty range falls out of ISSUE straight to DONE,
  // because the range check uses the values latched in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d; a missing branch
    // would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_key_process) state_d = S_ISSUE;
      S_ISSUE: state_d = range_left ? S_CHECK : S_DONE;
      S_CHECK: if (rec_ready) state_d = S_POP;
      S_POP:   state_d = (left_q == 32'd1) ? S_DRAIN : S_CHECK;
      S_DRAIN: if (burst_done) state_d = (range_left && !cap_reached) ? S_ISSUE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: next values for the registered outputs.
  always_comb begin
    go_d        = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    base_d      = control_read_base;
    len_d       = control_read_length;
    data_d      = fifo_data;
    count_d     = selected_count;
    busy_d      = busy;
    thr_d       = thr_q;
    end_d       = end_q;
    max_d       = max_q;
    cur_d       = cur_key_q;
    left_d      = left_q;
    done_seen_d = done_seen_q | control_done;
    unique case (state_q)
      S_IDLE: begin
        if (start_key_process) begin
          thr_d       = threshold;
          end_d       = key_end;
          max_d       = max_select;
          cur_d       = key_start;
          count_d     = 32'd0;
          busy_d      = 1'b1;
          done_seen_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (range_left) begin
          go_d        = 1'b1;
          base_d      = DDR_BASE + ADDRESS_WIDTH'({cur_key_q, 5'b0});
          len_d       = ADDRESS_WIDTH'({chunk, 5'b0});
          left_d      = chunk;
          done_seen_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (rec_ready) begin
          rd_d = 1'b1;
          // Past the cap the burst is still drained, just not written.
          if (qualifies && !cap_reached) begin
            wr_d    = 1'b1;
            data_d  = FIFO_DATA_WIDTH'({rec_delta, rec_key});
            count_d = selected_count + 32'd1;
          end
        end
      end
      S_POP: begin
        left_d = left_q - 32'd1;
        cur_d  = cur_key_q + 32'd1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered outputs and scan context.
  always_ff @(posedge clk) begin
    if (reset) begin
      control_read_base   <= '0;
      control_read_length <= '0;
      control_go          <= 1'b0;
      user_read_buffer    <= 1'b0;
      fifo_wrreq          <= 1'b0;
      fifo_data           <= '0;
      selected_count      <= 32'd0;
      key_selection_done  <= 1'b0;
      busy                <= 1'b0;
      thr_q               <= 32'd0;
      end_q               <= 32'd0;
      max_q               <= 32'd0;
      cur_key_q           <= 32'd0;
      left_q              <= 32'd0;
      done_seen_q         <= 1'b0;
    end else begin
      control_read_base   <= base_d;
      control_read_length <= len_d;
      control_go          <= go_d;
      user_read_buffer    <= rd_d;
      fifo_wrreq          <= wr_d;
      fifo_data           <= data_d;
      selected_count      <= count_d;
      key_selection_done  <= done_d;
      busy                <= busy_d;
      thr_q               <= thr_d;
      end_q               <= end_d;
      max_q               <= max_d;
      cur_key_q           <= cur_d;
      left_q              <= left_d;
      done_seen_q         <= done_seen_d;
    end
  end

endmodule

// File: tb/tb_top_k_select_scan.sv
// Testbench for top_k_select_scan: a burst read-master / record-source model
// plus an expectation model derived from the scan rules (which keys qualify,
// which bursts are issued, where the cap stops issuing), checked every cycle.
module tb_top_k_select_scan;

  localparam int AW = 31;

  logic           clk = 1'b0;
  logic           reset;
  logic           start_key_process;
  logic [31:0]    threshold, key_start, key_end, max_select;
  logic           control_fixed_location;
  logic [AW-1:0]  control_read_base, control_read_length;
  logic           control_go;
  logic           control_done;
  logic           user_read_buffer;
  logic           user_data_available;
  logic [255:0]   user_buffer_data;
  logic           fifo_wrreq;
  logic [63:0]    fifo_data;
  logic           fifo_almost_full;
  logic [31:0]    selected_count;
  logic           key_selection_done;
  logic           busy;

  always #5 clk = ~clk;

  top_k_select_scan #(
    .ADDRESS_WIDTH(AW), .DDR_BASE('0), .BURST_KEYS(8), .FIFO_DATA_WIDTH(64)
  ) dut (
    .clk(clk), .reset(reset), .start_key_process(start_key_process),
    .threshold(threshold), .key_start(key_start), .key_end(key_end),
    .max_select(max_select), .control_fixed_location(control_fixed_location),
    .control_read_base(control_read_base), .control_read_length(control_read_length),
    .control_go(control_go), .control_done(control_done),
    .user_read_buffer(user_read_buffer), .user_data_available(user_data_available),
    .user_buffer_data(user_buffer_data), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .fifo_almost_full(fifo_almost_full),
    .selected_count(selected_count), .key_selection_done(key_selection_done),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] delta_mem [0:63];

  // Expectations for the scan in progress.
  logic [63:0] exp_fifo[$];
  int          exp_base[$], exp_len[$];
  int          exp_writes, exp_bursts, exp_pops, exp_count, exp_pop_key;

  // Observations for the scan in progress.
  logic [63:0] fifo_log[$];
  int          base_log[$], len_log[$];
  int          cyc, start_cyc, go_cyc, done_cyc;
  int          pops_n, writes_n, dones_n;
  bit          scan_done;

  // Read-master model state and per-scan knobs.
  int rdq[$];
  int lat, done_tmr, stall_ctr, stall_at;
  bit burst_open, early_mode, stall_arm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [255:0] mkrec(input int k);
    return {160'd0, delta_mem[k], 32'hdeadbeef, 32'(k)};
  endfunction

  function automatic logic [63:0] log_at(input int i);
    return (i < fifo_log.size()) ? fifo_log[i] : 64'hffff_ffff_ffff_ffff;
  endfunction

  function automatic int blog_at(input int i, input bit want_len);
    if (want_len) return (i < len_log.size()) ? len_log[i] : -1;
    return (i < base_log.size()) ? base_log[i] : -1;
  endfunction

  // Walk the range burst by burst: every record of an issued burst is popped,
  // qualifying keys are emitted until the cap, and no burst follows the one
  // in which the cap was reached.
  function automatic void build_expect(input int ks, input int ke, input int thr_i, input int cap);
    int b, ch, sel, pops;
    exp_fifo.delete(); exp_base.delete(); exp_len.delete();
    b = ks; sel = 0; pops = 0;
    while (b < ke) begin
      ch = (ke - b < 8) ? ke - b : 8;
      exp_base.push_back(b * 32);
      exp_len.push_back(ch * 32);
      for (int k = b; k < b + ch; k++)
        if (delta_mem[k] >= 32'(thr_i) && (cap == 0 || sel < cap)) begin
          exp_fifo.push_back({delta_mem[k], 32'(k)});
          sel++;
        end
      pops += ch;
      b += ch;
      if (cap != 0 && sel == cap) break;
    end
    exp_writes = exp_fifo.size();
    exp_bursts = exp_base.size();
    exp_pops   = pops;
    exp_count  = sel;
  endfunction

  // Per-cycle compare process and read-master model. Outputs are sampled on
  // the falling edge; model inputs are updated after the checks.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rdq.delete(); exp_fifo.delete(); exp_base.delete(); exp_len.delete();
        control_done = 1'b0; user_data_available = 1'b0; user_buffer_data = '0;
        fifo_almost_full = 1'b0; lat = 0; burst_open = 1'b0; stall_ctr = 0; stall_arm = 1'b0;
      end else begin
        if (start_key_process && !busy) begin
          build_expect(int'(key_start), int'(key_end), int'(threshold), int'(max_select));
          exp_pop_key = int'(key_start);
          pops_n = 0; writes_n = 0; dones_n = 0; scan_done = 1'b0;
          start_cyc = cyc; go_cyc = -1; done_cyc = -1;
          fifo_log.delete(); base_log.delete(); len_log.delete();
          stall_arm = (stall_at >= 0);
        end
        if (control_go) begin
          base_log.push_back(int'(control_read_base));
          len_log.push_back(int'(control_read_length));
          if (go_cyc < 0) go_cyc = cyc;
          if (exp_base.size() != 0) begin
            check("burst_base", 64'(control_read_base), 64'(exp_base.pop_front()));
            check("burst_len", 64'(control_read_length), 64'(exp_len.pop_front()));
          end else check("burst_unexpected", 64'(control_go), 64'd0);
          for (int i = 0; i < int'(control_read_length) / 32; i++)
            rdq.push_back(int'(control_read_base) / 32 + i);
          lat = 2; burst_open = 1'b1; done_tmr = early_mode ? 3 : 0;
        end
        if (user_read_buffer) begin
          check("pop_while_empty", 64'(user_data_available), 64'd1);
          check("pop_during_stall", 64'(fifo_almost_full), 64'd0);
          if (rdq.size() != 0) begin
            check("pop_key_order", 64'(rdq[0]), 64'(exp_pop_key));
            exp_pop_key++;
            void'(rdq.pop_front());
          end else check("pop_no_record", 64'(rdq.size()), 64'd1);
          pops_n++;
        end
        if (fifo_wrreq) begin
          check("wr_without_pop", 64'(user_read_buffer), 64'd1);
          fifo_log.push_back(fifo_data);
          if (exp_fifo.size() != 0) check("fifo_data", fifo_data, exp_fifo.pop_front());
          else check("fifo_unexpected_write", 64'(fifo_wrreq), 64'd0);
          writes_n++;
        end
        if (key_selection_done) begin
          dones_n++;
          if (!scan_done) done_cyc = cyc;
          scan_done = 1'b1;
          check("busy_low_at_done", 64'(busy), 64'd0);
        end

        control_done = 1'b0;
        if (burst_open) begin
          if (early_mode) begin
            if (done_tmr > 0) begin
              done_tmr--;
              if (done_tmr == 0) begin control_done = 1'b1; burst_open = 1'b0; end
            end
          end else if (rdq.size() == 0) begin
            control_done = 1'b1; burst_open = 1'b0;
          end
        end
        if (lat > 0) lat--;
        user_data_available = (lat == 0) && (rdq.size() != 0);
        user_buffer_data    = user_data_available ? mkrec(rdq[0]) : '0;
        if (stall_arm && pops_n == stall_at) begin
          fifo_almost_full = 1'b1; stall_ctr = 20; stall_arm = 1'b0;
        end else if (stall_ctr > 0) begin
          stall_ctr--;
          if (stall_ctr == 0) fifo_almost_full = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_start(input int ks, input int ke, input int thr_i, input int cap);
    @(posedge clk); #1;
    start_key_process = 1'b1;
    key_start = 32'(ks); key_end = 32'(ke); threshold = 32'(thr_i); max_select = 32'(cap);
    @(posedge clk); #1;
    start_key_process = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic run_scan(input int ks, input int ke, input int thr_i, input int cap,
                          input bit early, input int stall);
    early_mode = early;
    stall_at   = stall;
    check("busy_idle_before_start", 64'(busy), 64'd0);
    pulse_start(ks, ke, thr_i, cap);
    for (int i = 0; i < 3000; i++) begin
      if (scan_done) break;
      @(negedge clk);
    end
    check("scan_completed", 64'(scan_done), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    check("done_pulses", 64'(dones_n), 64'd1);
    check("fifo_writes", 64'(writes_n), 64'(exp_writes));
    check("record_pops", 64'(pops_n), 64'(exp_pops));
    check("burst_count", 64'(base_log.size()), 64'(exp_bursts));
    check("selected_count", 64'(selected_count), 64'(exp_count));
    check("expected_writes_left", 64'(exp_fifo.size()), 64'd0);
    check("records_left", 64'(rdq.size()), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    if (exp_bursts > 0) check("go_latency", 64'(go_cyc - start_cyc), 64'd2);
  endtask

  initial begin
    reset = 1'b1; start_key_process = 1'b0;
    threshold = '0; key_start = '0; key_end = '0; max_select = '0;
    control_done = 1'b0; user_data_available = 1'b0; user_buffer_data = '0;
    fifo_almost_full = 1'b0; stall_at = -1; early_mode = 1'b0; cyc = 0;
    start_cyc = 0; go_cyc = -1; done_cyc = -1; pops_n = 0; writes_n = 0; dones_n = 0;
    scan_done = 1'b0; lat = 0; done_tmr = 0; stall_ctr = 0; burst_open = 1'b0; stall_arm = 1'b0;
    exp_writes = 0; exp_bursts = 0; exp_pops = 0; exp_count = 0; exp_pop_key = 0;
    for (int k = 0; k < 64; k++) delta_mem[k] = 32'd0;
    fork monitor(); join_none

    repeat (3) @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_go", 64'(control_go), 64'd0);
    check("rst_base", 64'(control_read_base), 64'd0);
    check("rst_len", 64'(control_read_length), 64'd0);
    check("rst_rd", 64'(user_read_buffer), 64'd0);
    check("rst_wr", 64'(fifo_wrreq), 64'd0);
    check("rst_data", fifo_data, 64'd0);
    check("rst_count", 64'(selected_count), 64'd0);
    check("rst_done", 64'(key_selection_done), 64'd0);
    check("fixed_location", 64'(control_fixed_location), 64'd0);
    reset = 1'b0;

    // [0,4), threshold 10, deltas {5,10,3,20}
    delta_mem[0] = 5; delta_mem[1] = 10; delta_mem[2] = 3; delta_mem[3] = 20;
    run_scan(0, 4, 10, 0, 1'b0, -1);
    check("t1_word0", log_at(0), 64'h0000_000a_0000_0001);
    check("t1_word1", log_at(1), 64'h0000_0014_0000_0003);
    check("t1_count", 64'(selected_count), 64'd2);
    check("t1_base", 64'(blog_at(0, 1'b0)), 64'd0);
    check("t1_len", 64'(blog_at(0, 1'b1)), 64'd128);

    // [3,20), delta = 3k, threshold 30, early control_done
    for (int k = 0; k < 64; k++) delta_mem[k] = 32'(3 * k);
    run_scan(3, 20, 30, 0, 1'b1, -1);
    check("t2_base0", 64'(blog_at(0, 1'b0)), 64'd96);
    check("t2_base1", 64'(blog_at(1, 1'b0)), 64'd352);
    check("t2_base2", 64'(blog_at(2, 1'b0)), 64'd608);
    check("t2_len0", 64'(blog_at(0, 1'b1)), 64'd256);
    check("t2_len1", 64'(blog_at(1, 1'b1)), 64'd256);
    check("t2_len2", 64'(blog_at(2, 1'b1)), 64'd32);
    check("t2_pops", 64'(pops_n), 64'd17);
    check("t2_count", 64'(selected_count), 64'd10);

    // Empty range [5,5): done three cycles after the start cycle
    run_scan(5, 5, 0, 0, 1'b0, -1);
    check("t3_done_latency", 64'(done_cyc - start_cyc), 64'd3);
    check("t3_no_burst", 64'(base_log.size()), 64'd0);
    check("t3_no_pop", 64'(pops_n), 64'd0);
    check("t3_count", 64'(selected_count), 64'd0);

    // All 16 deltas above threshold, cap 5
    for (int k = 0; k < 16; k++) delta_mem[k] = 32'(100 + k);
    run_scan(0, 16, 50, 5, 1'b0, -1);
    check("t4_writes", 64'(writes_n), 64'd5);
    check("t4_pops", 64'(pops_n), 64'd8);
    check("t4_bursts", 64'(base_log.size()), 64'd1);
    check("t4_last_word", log_at(4), {32'd104, 32'd4});

    // fifo_almost_full held 20 cycles after the third pop
    for (int k = 0; k < 16; k++) delta_mem[k] = (k % 3 == 0) ? 32'd1000 : 32'd1;
    run_scan(0, 16, 500, 0, 1'b0, 3);
    check("t5_count", 64'(selected_count), 64'd6);
    check("t5_last_word", log_at(5), {32'd1000, 32'd15});

    // Reset mid-burst, then a fresh scan
    early_mode = 1'b0; stall_at = -1;
    pulse_start(0, 16, 0, 0);
    for (int i = 0; i < 500; i++) begin
      if (pops_n >= 5) break;
      @(negedge clk);
    end
    check("t6_reached_mid_burst", 64'(pops_n >= 5), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_go", 64'(control_go), 64'd0);
    check("t6_rst_base", 64'(control_read_base), 64'd0);
    check("t6_rst_len", 64'(control_read_length), 64'd0);
    check("t6_rst_rd", 64'(user_read_buffer), 64'd0);
    check("t6_rst_wr", 64'(fifo_wrreq), 64'd0);
    check("t6_rst_data", fifo_data, 64'd0);
    check("t6_rst_count", 64'(selected_count), 64'd0);
    check("t6_rst_done", 64'(key_selection_done), 64'd0);
    reset = 1'b0;
    run_scan(2, 11, 500, 0, 1'b0, -1);
    check("t6_count", 64'(selected_count), 64'd3);
    check("t6_pops", 64'(pops_n), 64'd9);
    check("t6_base1", 64'(blog_at(1, 1'b0)), 64'd320);
    check("t6_len1", 64'(blog_at(1, 1'b1)), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
